// File: rtl/cacheline_burst_adapter_pkg.sv
// Shared types and default sizing for the cache-line to burst-memory adapter.
// Contents: default ADDR_W/LINE_W/BEAT_W, derived BURST_LEN, adapter FSM states.
package cacheline_burst_adapter_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned LINE_W    = 256;
  localparam int unsigned BEAT_W    = 64;
  localparam int unsigned BURST_LEN = LINE_W / BEAT_W;

  // Adapter transaction phases.
  typedef enum logic [2:0] {
    IDLE,
    RD_CMD,
    RD_COLLECT,
    WR_BURST,
    RESP
  } adapter_state_t;

endpackage

// File: rtl/cacheline_burst_adapter_assembler.sv
// Line assembly buffer: drops each returned read beat into its slice of a line.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   beat_valid  write beat_data into slice beat_idx this cycle
//   beat_idx    beat position, 0 = least-significant slice
//   beat_data   returned beat
//   line_c      buffer contents including this cycle's beat (combinational)
module cacheline_burst_adapter_assembler #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned BEAT_W = 64,
  parameter int unsigned CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              beat_valid,
  input  logic [CNT_W-1:0]  beat_idx,
  input  logic [BEAT_W-1:0] beat_data,
  output logic [LINE_W-1:0] line_c
);

  logic [LINE_W-1:0] line_q, line_d;

  // Merge the incoming beat so the final beat is visible the cycle it arrives.
  always_comb begin
    line_d = line_q;
    if (beat_valid) begin
      line_d[32'(beat_idx) * BEAT_W +: BEAT_W] = beat_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign line_c = line_d;

endmodule

// File: rtl/cacheline_burst_adapter.sv
// Converts full-line DFP reads/writes from a cache controller into
// BURST_LEN-beat transactions on a narrow burst-memory bus.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   dfp_addr/read/write/wdata        line request from cache (held until dfp_resp)
//   dfp_rdata, dfp_resp              assembled read line, one-cycle completion pulse
//   bmem_addr/read/write/wdata       burst command / write beat to memory
//   bmem_ready                       memory accepts command or beat this cycle
//   bmem_rdata, bmem_rvalid          returned read beat
module cacheline_burst_adapter #(
  parameter int unsigned ADDR_W = cacheline_burst_adapter_pkg::ADDR_W,
  parameter int unsigned LINE_W = cacheline_burst_adapter_pkg::LINE_W,
  parameter int unsigned BEAT_W = cacheline_burst_adapter_pkg::BEAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] dfp_addr,
  input  logic              dfp_read,
  input  logic              dfp_write,
  input  logic [LINE_W-1:0] dfp_wdata,
  output logic [LINE_W-1:0] dfp_rdata,
  output logic              dfp_resp,
  output logic [ADDR_W-1:0] bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);

  import cacheline_burst_adapter_pkg::*;

  localparam int unsigned BURST_LEN = LINE_W / BEAT_W;
  localparam int unsigned CNT_W     = $clog2(BURST_LEN);
  localparam int unsigned OFF_W     = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  adapter_state_t    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] wline_q, wline_d;
  logic [LINE_W-1:0] dfp_rdata_q, dfp_rdata_d;
  logic              dfp_resp_q, dfp_resp_d;
  logic [ADDR_W-1:0] bmem_addr_q, bmem_addr_d;
  logic              bmem_read_q, bmem_read_d;
  logic              bmem_write_q, bmem_write_d;
  logic [BEAT_W-1:0] bmem_wdata_q, bmem_wdata_d;

  logic              beat_valid_c;
  logic [LINE_W-1:0] asm_line_c;
  logic [ADDR_W-1:0] line_addr_c;
  logic              addr_unused_c;

  // Byte offset within the line is meaningless to the burst memory.
  assign line_addr_c   = {dfp_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
  assign addr_unused_c = ^dfp_addr[OFF_W-1:0];

  // rvalid outside the collect phase never reaches the line buffer.
  assign beat_valid_c = (state_q == RD_COLLECT) && bmem_rvalid;

  cacheline_burst_adapter_assembler #(
    .LINE_W (LINE_W),
    .BEAT_W (BEAT_W),
    .CNT_W  (CNT_W)
  ) u_assembler (
    .clk        (clk),
    .rst        (rst),
    .beat_valid (beat_valid_c),
    .beat_idx   (cnt_q),
    .beat_data  (bmem_rdata),
    .line_c     (asm_line_c)
  );

  // Next state plus next values of the registered outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wline_d      = wline_q;
    dfp_rdata_d  = dfp_rdata_q;
    bmem_addr_d  = bmem_addr_q;
    bmem_read_d  = 1'b0;
    bmem_write_d = 1'b0;
    bmem_wdata_d = '0;
    dfp_resp_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (dfp_write) begin
          bmem_addr_d = line_addr_c;
          wline_d     = dfp_wdata;
          state_d     = WR_BURST;
        end else if (dfp_read) begin
          bmem_addr_d = line_addr_c;
          state_d     = RD_CMD;
        end
      end
      RD_CMD: begin
        if (bmem_ready) begin
          cnt_d   = '0;
          state_d = RD_COLLECT;
        end
      end
      RD_COLLECT: begin
        if (bmem_rvalid) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d       = '0;
            dfp_rdata_d = asm_line_c;
            state_d     = RESP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      WR_BURST: begin
        if (bmem_ready) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = RESP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // Outputs follow the state being entered so they line up with it.
    bmem_read_d  = (state_d == RD_CMD);
    bmem_write_d = (state_d == WR_BURST);
    dfp_resp_d   = (state_d == RESP);
    if (state_d == WR_BURST) begin
      bmem_wdata_d = wline_d[32'(cnt_d) * BEAT_W +: BEAT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wline_q      <= '0;
      dfp_rdata_q  <= '0;
      dfp_resp_q   <= 1'b0;
      bmem_addr_q  <= '0;
      bmem_read_q  <= 1'b0;
      bmem_write_q <= 1'b0;
      bmem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wline_q      <= wline_d;
      dfp_rdata_q  <= dfp_rdata_d;
      dfp_resp_q   <= dfp_resp_d;
      bmem_addr_q  <= bmem_addr_d;
      bmem_read_q  <= bmem_read_d;
      bmem_write_q <= bmem_write_d;
      bmem_wdata_q <= bmem_wdata_d;
    end
  end

  assign dfp_rdata  = dfp_rdata_q;
  assign dfp_resp   = dfp_resp_q;
  assign bmem_addr  = bmem_addr_q;
  assign bmem_read  = bmem_read_q;
  assign bmem_write = bmem_write_q;
  assign bmem_wdata = bmem_wdata_q;

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Self-checking bench for cacheline_burst_adapter with a behavioural
// burst-memory model and a line-level reference model.
module tb_cacheline_burst_adapter;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 256;
  localparam int unsigned BW = 64;
  localparam int unsigned BL = LW / BW;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] dfp_addr;
  logic          dfp_read, dfp_write;
  logic [LW-1:0] dfp_wdata, dfp_rdata;
  logic          dfp_resp;
  logic [AW-1:0] bmem_addr;
  logic          bmem_read, bmem_write;
  logic [BW-1:0] bmem_wdata;
  logic          bmem_ready;
  logic [BW-1:0] bmem_rdata;
  logic          bmem_rvalid;

  always #5 clk = ~clk;

  cacheline_burst_adapter #(.ADDR_W(AW), .LINE_W(LW), .BEAT_W(BW)) dut (
    .clk         (clk),
    .rst         (rst),
    .dfp_addr    (dfp_addr),
    .dfp_read    (dfp_read),
    .dfp_write   (dfp_write),
    .dfp_wdata   (dfp_wdata),
    .dfp_rdata   (dfp_rdata),
    .dfp_resp    (dfp_resp),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_write  (bmem_write),
    .bmem_wdata  (bmem_wdata),
    .bmem_ready  (bmem_ready),
    .bmem_rdata  (bmem_rdata),
    .bmem_rvalid (bmem_rvalid)
  );

  int checks = 0;
  int errors = 0;

  // Observations gathered by run_txn for one transaction.
  logic [BW-1:0] mem_beat [BL];
  logic [AW-1:0] r_addr;
  bit            r_addr_bad, r_timeout;
  int            r_rd_cyc, r_wr_cyc, r_resp, r_resp_cyc, r_first_cyc, r_last_cyc;
  logic          r_post_resp, r_post_busy;
  logic [LW-1:0] r_line;
  logic [BW-1:0] r_ws [$];
  logic [BW-1:0] exp_ws [$];
  logic [LW-1:0] last_line;

  // Reference: the line is the beats with beat 0 least significant.
  function automatic logic [LW-1:0] model_line();
    logic [LW-1:0] l = '0;
    for (int i = BL - 1; i >= 0; i--) l = (l << BW) | LW'(mem_beat[i]);
    return l;
  endfunction

  // Reference: one entry per write-valid cycle; the beat moves on when memory is ready.
  task automatic model_wstream(input logic [LW-1:0] wd, input logic [31:0] stall);
    int acc = 0;
    int j = 0;
    exp_ws.delete();
    while (acc < int'(BL)) begin
      exp_ws.push_back(BW'(wd >> (BW * acc)));
      if (!(j < 32 && stall[j])) acc++;
      j++;
    end
  endtask

  // Reference: cycles bmem_read stays up = leading stalled handshakes + 1.
  function automatic int model_cmd_cycles(input logic [31:0] stall);
    int j = 0;
    while (j < 32 && stall[j]) j++;
    return j + 1;
  endfunction

  task automatic fill_beats();
    for (int i = 0; i < int'(BL); i++) mem_beat[i] = {$urandom, $urandom};
  endtask

  task automatic idle_cycles(input int n);
    bmem_ready = 1'b0; bmem_rvalid = 1'b0;
    repeat (n) begin @(posedge clk); @(negedge clk); end
  endtask

  // Drives one cache request and plays the burst memory; called at a negedge.
  // stall[j]: j-th command/beat cycle sees bmem_ready low. gap[k]: k-th collect cycle has no beat.
  task automatic run_txn(input bit rd, input bit wr, input logic [AW-1:0] addr,
                         input logic [LW-1:0] wd, input logic [31:0] stall,
                         input logic [31:0] gap, input int rst_beat,
                         input bit drop_early, input bit junk);
    int j = 0, k = 0, sent = 0, n = 0;
    bit collect = 0, done = 0, first = 1;
    logic [AW-1:0] al = addr & ~AW'(LW / 8 - 1);
    r_addr = '0; r_addr_bad = 0; r_timeout = 0;
    r_rd_cyc = 0; r_wr_cyc = 0; r_resp = 0; r_resp_cyc = -1; r_first_cyc = -1; r_last_cyc = -1;
    r_line = '0; r_post_resp = 1'bx; r_post_busy = 1'bx; r_ws.delete();
    dfp_read = rd; dfp_write = wr; dfp_addr = addr; dfp_wdata = wd;
    while (!done) begin
      @(posedge clk); @(negedge clk); n++;
      if (n > 300) begin r_timeout = 1; break; end
      bmem_ready = 1'b0; bmem_rvalid = 1'b0;
      bmem_rdata = junk ? {$urandom, $urandom} : '0;
      if (collect && sent < int'(BL)) begin
        if (rst_beat == sent) begin
          rst = 1'b1; done = 1;
        end else if (!(k < 32 && gap[k])) begin
          bmem_rvalid = 1'b1; bmem_rdata = mem_beat[sent]; sent++;
          if (sent == int'(BL)) r_last_cyc = n;
        end
        k++;
      end else if (junk) begin
        bmem_rvalid = 1'($urandom_range(0, 1));
      end
      if (bmem_read || bmem_write) begin
        if (first) begin r_addr = bmem_addr; r_first_cyc = n; first = 0; end
        if (bmem_addr !== al) r_addr_bad = 1;
        bmem_ready = !(j < 32 && stall[j]);
        j++;
        if (bmem_read) begin
          r_rd_cyc++;
          if (bmem_ready) collect = 1;
        end
        if (bmem_write) begin
          r_wr_cyc++;
          r_ws.push_back(bmem_wdata);
          if (bmem_ready) r_last_cyc = n;
        end
        if (drop_early) begin dfp_read = 1'b0; dfp_write = 1'b0; end
      end else if (junk) begin
        bmem_ready = 1'($urandom_range(0, 1));
      end
      if (dfp_resp) begin
        r_resp++; r_resp_cyc = n; r_line = dfp_rdata;
        dfp_read = 1'b0; dfp_write = 1'b0; done = 1;
      end
    end
    dfp_read = 1'b0; dfp_write = 1'b0;
    if (!r_timeout) begin
      bmem_ready = 1'b0; bmem_rvalid = 1'b0;
      @(posedge clk); @(negedge clk);
      r_post_resp = dfp_resp;
      r_post_busy = bmem_read | bmem_write;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; dfp_read = 0; dfp_write = 0; dfp_addr = '0; dfp_wdata = '0;
    bmem_ready = 0; bmem_rdata = '0; bmem_rvalid = 0;
    repeat (3) @(negedge clk);
    checks++; if (dfp_resp !== 1'b0) begin errors++; $display("FAIL reset_dfp_resp: got %b want 0", dfp_resp); end
    checks++; if (bmem_read !== 1'b0) begin errors++; $display("FAIL reset_bmem_read: got %b want 0", bmem_read); end
    checks++; if (bmem_write !== 1'b0) begin errors++; $display("FAIL reset_bmem_write: got %b want 0", bmem_write); end
    checks++; if (dfp_rdata !== '0) begin errors++; $display("FAIL reset_dfp_rdata: got %h want 0", dfp_rdata); end
    checks++; if (bmem_addr !== '0) begin errors++; $display("FAIL reset_bmem_addr: got %h want 0", bmem_addr); end
    checks++; if (bmem_wdata !== '0) begin errors++; $display("FAIL reset_bmem_wdata: got %h want 0", bmem_wdata); end
    rst = 1'b0;
    last_line = '0;
  endtask

  int base_lat;

  task automatic test_read_basic();
    logic [LW-1:0] exp;
    mem_beat[0] = 64'h1111_1111_1111_1111; mem_beat[1] = 64'h2222_2222_2222_2222;
    mem_beat[2] = 64'h3333_3333_3333_3333; mem_beat[3] = 64'h4444_4444_4444_4444;
    exp = model_line();
    run_txn(1, 0, 32'h0000_1234, '0, 32'h0, 32'h0, -1, 0, 0);
    base_lat = r_resp_cyc - r_first_cyc;
    checks++; if (r_timeout) begin errors++; $display("FAIL rd_basic_timeout: no dfp_resp within budget"); end
    checks++; if (r_addr !== 32'h0000_1220 || r_addr_bad) begin errors++; $display("FAIL rd_basic_addr: got %h want 00001220", r_addr); end
    checks++; if (r_resp != 1 || r_post_resp !== 1'b0) begin errors++; $display("FAIL rd_basic_resp: got %0d pulses post=%b want 1/0", r_resp, r_post_resp); end
    checks++; if (r_line !== exp) begin errors++; $display("FAIL rd_basic_line: got %h want %h", r_line, exp); end
    checks++; if (r_rd_cyc != 1 || r_wr_cyc != 0) begin errors++; $display("FAIL rd_basic_cmd: got rd=%0d wr=%0d want 1/0", r_rd_cyc, r_wr_cyc); end
    checks++; if (r_resp_cyc != r_last_cyc + 1) begin errors++; $display("FAIL rd_basic_latency: got resp@%0d want %0d", r_resp_cyc, r_last_cyc + 1); end
    last_line = exp;
  endtask

  task automatic test_read_gap();
    logic [LW-1:0] exp;
    fill_beats();
    exp = model_line();
    run_txn(1, 0, 32'h0000_1234, '0, 32'h0, 32'b100, -1, 0, 0);
    checks++; if (r_timeout || r_resp != 1) begin errors++; $display("FAIL rd_gap_resp: got %0d pulses want 1", r_resp); end
    checks++; if (r_line !== exp) begin errors++; $display("FAIL rd_gap_line: got %h want %h", r_line, exp); end
    checks++; if (r_resp_cyc - r_first_cyc != base_lat + 1) begin errors++; $display("FAIL rd_gap_latency: got %0d want %0d", r_resp_cyc - r_first_cyc, base_lat + 1); end
    last_line = exp;
  endtask

  task automatic test_write_stall();
    logic [BW-1:0] want [$];
    logic [LW-1:0] wd;
    bit ok;
    wd = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    want = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 64'h2222_2222_2222_2222,
             64'h2222_2222_2222_2222, 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    run_txn(0, 1, 32'h0000_0080, wd, 32'b0110, 32'h0, -1, 0, 0);
    ok = (r_ws.size() == want.size());
    for (int i = 0; ok && i < want.size(); i++) if (r_ws[i] !== want[i]) ok = 0;
    checks++; if (!ok) begin errors++; $display("FAIL wr_stall_beats: got %0d beats first=%h want %0d beats", r_ws.size(), (r_ws.size() > 0) ? r_ws[0] : '0, want.size()); end
    checks++; if (r_timeout || r_resp != 1 || r_post_resp !== 1'b0) begin errors++; $display("FAIL wr_stall_resp: got %0d pulses want 1", r_resp); end
    checks++; if (r_addr !== 32'h0000_0080 || r_addr_bad || r_rd_cyc != 0) begin errors++; $display("FAIL wr_stall_addr: got %h rd=%0d want 00000080 rd=0", r_addr, r_rd_cyc); end
    checks++; if (r_line !== last_line) begin errors++; $display("FAIL wr_keeps_rdata: got %h want %h", r_line, last_line); end
    checks++; if (r_resp_cyc != r_last_cyc + 1) begin errors++; $display("FAIL wr_stall_latency: got resp@%0d want %0d", r_resp_cyc, r_last_cyc + 1); end
  endtask

  task automatic test_both_high();
    logic [LW-1:0] wd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    bit ok;
    model_wstream(wd, 32'h0);
    run_txn(1, 1, 32'h0000_4440, wd, 32'h0, 32'h0, -1, 0, 0);
    ok = (r_ws.size() == exp_ws.size());
    for (int i = 0; ok && i < exp_ws.size(); i++) if (r_ws[i] !== exp_ws[i]) ok = 0;
    checks++; if (r_rd_cyc != 0) begin errors++; $display("FAIL both_no_read: got %0d read cycles want 0", r_rd_cyc); end
    checks++; if (!ok || r_resp != 1) begin errors++; $display("FAIL both_write_burst: got %0d beats %0d pulses want %0d/1", r_ws.size(), r_resp, exp_ws.size()); end
  endtask

  task automatic test_reset_mid();
    logic [LW-1:0] exp;
    fill_beats();
    run_txn(1, 0, 32'h0000_2000, '0, 32'h0, 32'h0, 2, 0, 0);
    checks++; if ({dfp_resp, bmem_read, bmem_write} !== 3'b000 || bmem_addr !== '0 || bmem_wdata !== '0 || dfp_rdata !== '0)
      begin errors++; $display("FAIL rst_mid_outputs: got resp=%b rd=%b wr=%b addr=%h rdata=%h want all 0", dfp_resp, bmem_read, bmem_write, bmem_addr, dfp_rdata); end
    rst = 1'b0;
    last_line = '0;
    fill_beats();
    exp = model_line();
    run_txn(1, 0, 32'h0000_2040, '0, 32'h0, 32'h0, -1, 0, 0);
    checks++; if (r_timeout || r_resp != 1 || r_line !== exp) begin errors++; $display("FAIL rst_mid_recover: got %0d pulses line %h want 1 line %h", r_resp, r_line, exp); end
    checks++; if (r_addr !== 32'h0000_2040 || r_rd_cyc != 1) begin errors++; $display("FAIL rst_mid_recover_addr: got %h rd=%0d want 00002040 rd=1", r_addr, r_rd_cyc); end
    last_line = exp;
  endtask

  task automatic test_back_to_back();
    logic [LW-1:0] exp_a, exp_b;
    logic [AW-1:0] a, b;
    a = 32'h0001_0000 | AW'($urandom_range(0, 255));
    b = a + 32'h40;
    fill_beats(); exp_a = model_line();
    run_txn(1, 0, a, '0, 32'h0, 32'h0, -1, 0, 0);
    checks++; if (r_resp != 1 || r_line !== exp_a || r_addr !== (a & ~32'h1f) || r_post_busy !== 1'b0)
      begin errors++; $display("FAIL b2b_first: got %0d pulses addr %h busy=%b want 1 %h 0", r_resp, r_addr, r_post_busy, a & ~32'h1f); end
    fill_beats(); exp_b = model_line();
    run_txn(1, 0, b, '0, 32'h0, 32'h0, -1, 0, 0);
    checks++; if (r_resp != 1 || r_line !== exp_b || r_addr !== (b & ~32'h1f) || r_rd_cyc != 1)
      begin errors++; $display("FAIL b2b_second: got %0d pulses addr %h want 1 %h", r_resp, r_addr, b & ~32'h1f); end
    last_line = exp_b;
    idle_cycles(3);
    checks++; if ({dfp_resp, bmem_read, bmem_write} !== 3'b000) begin errors++; $display("FAIL b2b_quiet: got resp=%b rd=%b wr=%b want 000", dfp_resp, bmem_read, bmem_write); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      int kind = $urandom_range(0, 2);
      logic [AW-1:0] addr = $urandom;
      logic [LW-1:0] wd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      logic [31:0] stall = $urandom & $urandom;
      logic [31:0] gap = $urandom & $urandom;
      bit drop = 1'($urandom_range(0, 1));
      logic [LW-1:0] exp;
      bit ok;
      fill_beats();
      exp = model_line();
      if (kind != 0) model_wstream(wd, stall);
      run_txn(kind != 1, kind != 0, addr, wd, stall, gap, -1, drop, 1);
      checks++; if (r_timeout || r_resp != 1 || r_post_resp !== 1'b0)
        begin errors++; $display("FAIL rand_resp[%0d]: got %0d pulses post=%b want 1/0", it, r_resp, r_post_resp); end
      checks++; if (r_addr !== (addr & ~32'h1f) || r_addr_bad)
        begin errors++; $display("FAIL rand_addr[%0d]: got %h want %h", it, r_addr, addr & ~32'h1f); end
      checks++; if (r_resp_cyc != r_last_cyc + 1)
        begin errors++; $display("FAIL rand_latency[%0d]: got resp@%0d want %0d", it, r_resp_cyc, r_last_cyc + 1); end
      if (kind == 0) begin
        checks++; if (r_line !== exp || r_rd_cyc != model_cmd_cycles(stall) || r_wr_cyc != 0)
          begin errors++; $display("FAIL rand_read[%0d]: got line %h rd=%0d want %h rd=%0d", it, r_line, r_rd_cyc, exp, model_cmd_cycles(stall)); end
        last_line = exp;
      end else begin
        ok = (r_ws.size() == exp_ws.size()) && (r_rd_cyc == 0) && (r_line === last_line);
        for (int i = 0; ok && i < exp_ws.size(); i++) if (r_ws[i] !== exp_ws[i]) ok = 0;
        checks++; if (!ok)
          begin errors++; $display("FAIL rand_write[%0d]: got %0d beats rd=%0d want %0d beats rd=0", it, r_ws.size(), r_rd_cyc, exp_ws.size()); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_read_gap();
    test_write_stall();
    test_both_high();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
